debug_capture_unit: RTL and testbench

- Parametrised successor to the single CPDR debug register in the CPU top.
- Captures 32-bit integer-register values on every CPDR execute strobe into NUM_CH per-channel "latest value" registers.
- Also pushes each capture into a DEPTH-entry FIFO, drained over a valid/ready stream by a UART or LED bridge.
- Sits beside the Controller/DataPath; its capture strobe is opcode 8'hD3 decoded in STATE_EXEC.

---
 rtl/debug_capture_unit_pkg.sv | 22 ++
 rtl/debug_capture_unit_if.sv | 30 +++
 rtl/debug_capture_unit_fifo.sv | 85 ++++++++
 rtl/debug_capture_unit.sv | 81 ++++++++
 tb/tb_debug_capture_unit.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/debug_capture_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : debug_capture_unit_pkg
//  Purpose  : Shared constants and helpers for the CPDR debug capture unit.
//  Revision : 1.0 - initial release
// ============================================================================
package debug_capture_unit_pkg;

    // Opcode of the CPDR instruction; the capture strobe is this decoded in EXEC.
    localparam logic [7:0] c_op_cpdr = 8'hD3;

    // Full-FIFO policy selectors for the OVF_MODE parameter.
    localparam int c_ovf_drop_new = 0;
    localparam int c_ovf_drop_old = 1;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : debug_capture_unit_pkg
`default_nettype wire

// File: rtl/debug_capture_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : debug_capture_unit_if
//  Purpose  : Capture strobe input and valid/ready drain stream of the unit.
//  Revision : 1.0 - initial release
// ============================================================================
interface debug_capture_unit_if #(
    parameter int DATA_W = 32,
    parameter int CH_W   = 2
);
    logic              cap_valid;
    logic [CH_W-1:0]   cap_ch;
    logic [DATA_W-1:0] cap_data;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CH_W-1:0]   out_ch;

    modport master (
        output cap_valid, cap_ch, cap_data, out_ready,
        input  out_valid, out_data, out_ch
    );

    modport slave (
        input  cap_valid, cap_ch, cap_data, out_ready,
        output out_valid, out_data, out_ch
    );
endinterface : debug_capture_unit_if
`default_nettype wire

// File: rtl/debug_capture_unit_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : debug_capture_unit_fifo
//  Purpose  : First-word-fall-through sync FIFO with selectable full policy.
//  Revision : 1.0 - initial release
// ============================================================================
module debug_capture_unit_fifo
    import debug_capture_unit_pkg::*;
#(
    parameter int WIDTH    = 34,
    parameter int DEPTH    = 16,
    parameter int OVF_MODE = c_ovf_drop_new
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_head,
    output logic [count_w(DEPTH)-1:0]  o_count,
    output logic                       o_ovf_event
);

    localparam int              c_aw      = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_full    = (c_aw + 1)'(DEPTH);
    localparam logic [c_aw:0]   c_cnt_one = (c_aw + 1)'(1);
    localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_drop_old;
    logic w_write;
    logic w_rd_adv;

    // A pop on an empty FIFO is ignored, so a simultaneous push never bypasses.
    always_comb begin
        w_empty    = (r_count == '0);
        w_full     = (r_count == c_full);
        w_pop      = i_pop && !w_empty;
        w_drop_old = i_push && w_full && !w_pop && (OVF_MODE == c_ovf_drop_old);
        w_write    = i_push && (!w_full || w_pop || w_drop_old);
        w_rd_adv   = w_pop || w_drop_old;
    end

    assign o_ovf_event = i_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd_adv) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_write && !w_rd_adv) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_write && w_rd_adv) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_valid = !w_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule : debug_capture_unit_fifo
`default_nettype wire

// File: rtl/debug_capture_unit.sv
`default_nettype none
// ============================================================================
//  Module   : debug_capture_unit
//  Purpose  : Per-channel CPDR latest-value registers plus queued capture log.
//  Revision : 1.0 - initial release
// ============================================================================
module debug_capture_unit
    import debug_capture_unit_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_CH   = 4,
    parameter int CH_W     = 2,
    parameter int DEPTH    = 16,
    parameter int OVF_MODE = c_ovf_drop_new
) (
    input  logic                       clk,
    input  logic                       reset,
    debug_capture_unit_if.slave        bus,
    output logic [NUM_CH*DATA_W-1:0]   dr_flat,
    output logic [count_w(DEPTH)-1:0]  count,
    output logic                       overflow,
    input  logic                       clear_ovf
);

    localparam logic [CH_W:0] c_num_ch = (CH_W + 1)'(NUM_CH);

    logic                     w_cap_ok;
    logic                     w_ovf_event;
    logic [CH_W+DATA_W-1:0]   w_head;

    // Out-of-range channels are dropped before they reach either the registers or the FIFO.
    assign w_cap_ok = bus.cap_valid && ({1'b0, bus.cap_ch} < c_num_ch);

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            localparam logic [CH_W-1:0] c_idx = CH_W'(k);
            logic [DATA_W-1:0] r_dr;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_dr <= '0;
                end else if (w_cap_ok && (bus.cap_ch == c_idx)) begin
                    r_dr <= bus.cap_data;
                end
            end

            assign dr_flat[k*DATA_W +: DATA_W] = r_dr;
        end
    endgenerate

    debug_capture_unit_fifo #(
        .WIDTH    (CH_W + DATA_W),
        .DEPTH    (DEPTH),
        .OVF_MODE (OVF_MODE)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (w_cap_ok),
        .i_push_data ({bus.cap_ch, bus.cap_data}),
        .i_pop       (bus.out_ready),
        .o_valid     (bus.out_valid),
        .o_head      (w_head),
        .o_count     (count),
        .o_ovf_event (w_ovf_event)
    );

    assign {bus.out_ch, bus.out_data} = w_head;

    // A fresh overflow outranks a same-cycle clear so no drop goes unreported.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (w_ovf_event) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule : debug_capture_unit
`default_nettype wire

// File: tb/tb_debug_capture_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_debug_capture_unit
//  Purpose  : Directed bench over three configurations of debug_capture_unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_debug_capture_unit;
    import debug_capture_unit_pkg::*;

    localparam int DW    = 32;
    localparam int CW    = 2;
    localparam int DEPTH = 16;
    localparam int CNTW  = count_w(DEPTH);

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    opcode;
    logic          in_exec;
    logic          cap_valid;
    logic [CW-1:0] cap_ch;
    logic [DW-1:0] cap_data;
    logic          out_ready;
    logic          clear_ovf;

    always #5 clk = ~clk;

    assign cap_valid = (opcode == c_op_cpdr) && in_exec;

    // a: 4 channels drop-new, b: 4 channels drop-old, c: 3 channels drop-new
    debug_capture_unit_if #(.DATA_W(DW), .CH_W(CW)) if_a ();
    debug_capture_unit_if #(.DATA_W(DW), .CH_W(CW)) if_b ();
    debug_capture_unit_if #(.DATA_W(DW), .CH_W(CW)) if_c ();

    assign if_a.cap_valid = cap_valid; assign if_a.cap_ch = cap_ch;
    assign if_a.cap_data  = cap_data;  assign if_a.out_ready = out_ready;
    assign if_b.cap_valid = cap_valid; assign if_b.cap_ch = cap_ch;
    assign if_b.cap_data  = cap_data;  assign if_b.out_ready = out_ready;
    assign if_c.cap_valid = cap_valid; assign if_c.cap_ch = cap_ch;
    assign if_c.cap_data  = cap_data;  assign if_c.out_ready = out_ready;

    logic [4*DW-1:0] dr_a, dr_b;
    logic [3*DW-1:0] dr_c;
    logic [CNTW-1:0] cnt_a, cnt_b, cnt_c;
    logic            ovf_a, ovf_b, ovf_c;

    debug_capture_unit #(.DATA_W(DW), .NUM_CH(4), .CH_W(CW), .DEPTH(DEPTH),
                         .OVF_MODE(c_ovf_drop_new)) u_dut_a (
        .clk(clk), .reset(reset), .bus(if_a.slave), .dr_flat(dr_a),
        .count(cnt_a), .overflow(ovf_a), .clear_ovf(clear_ovf));

    debug_capture_unit #(.DATA_W(DW), .NUM_CH(4), .CH_W(CW), .DEPTH(DEPTH),
                         .OVF_MODE(c_ovf_drop_old)) u_dut_b (
        .clk(clk), .reset(reset), .bus(if_b.slave), .dr_flat(dr_b),
        .count(cnt_b), .overflow(ovf_b), .clear_ovf(clear_ovf));

    debug_capture_unit #(.DATA_W(DW), .NUM_CH(3), .CH_W(CW), .DEPTH(DEPTH),
                         .OVF_MODE(c_ovf_drop_new)) u_dut_c (
        .clk(clk), .reset(reset), .bus(if_c.slave), .dr_flat(dr_c),
        .count(cnt_c), .overflow(ovf_c), .clear_ovf(clear_ovf));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [CW-1:0] ch, input logic [DW-1:0] data);
        opcode   = c_op_cpdr;
        in_exec  = 1'b1;
        cap_ch   = ch;
        cap_data = data;
        tick();
        in_exec  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [CW-1:0] seq_ch [3] = '{2'd0, 2'd1, 2'd0};
    logic [DW-1:0] seq_d  [3] = '{32'd1, 32'd2, 32'd3};

    initial begin
        reset     = 1'b1;
        opcode    = 8'h00;
        in_exec   = 1'b0;
        cap_ch    = '0;
        cap_data  = '0;
        out_ready = 1'b0;
        clear_ovf = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_dr_a",    dr_a, '0);
        check("rst_dr_c",    dr_c, '0);
        check("rst_cnt_a",   cnt_a, '0);
        check("rst_valid_a", if_a.out_valid, 1'b0);
        check("rst_ovf_a",   ovf_a, 1'b0);

        // Single capture on channel 2
        capture(2'd2, 32'hDEADBEEF);
        check("cap_dr_a",   dr_a, {32'h0, 32'hDEADBEEF, 64'h0});
        check("cap_dr_b",   dr_b, {32'h0, 32'hDEADBEEF, 64'h0});
        check("cap_dr_c",   dr_c, {32'hDEADBEEF, 64'h0});
        check("cap_valid",  if_a.out_valid, 1'b1);
        check("cap_ch_a",   if_a.out_ch, 2'd2);
        check("cap_data_a", if_a.out_data, 32'hDEADBEEF);
        check("cap_ch_b",   if_b.out_ch, 2'd2);
        check("cap_data_b", if_b.out_data, 32'hDEADBEEF);
        check("cap_ch_c",   if_c.out_ch, 2'd2);
        check("cap_data_c", if_c.out_data, 32'hDEADBEEF);
        check("cap_cnt",    cnt_a, 5'd1);
        out_ready = 1'b1;
        tick();
        check("pop1_cnt",   cnt_a, 5'd0);
        tick();
        check("pop_empty_cnt", cnt_a, 5'd0);

        // Push into empty FIFO with ready held high: no bypass
        capture(2'd1, 32'h42);
        check("nobypass_cnt",  cnt_a, 5'd1);
        check("nobypass_data", if_a.out_data, 32'h42);
        tick();
        out_ready = 1'b0;
        check("nobypass_drain", cnt_a, 5'd0);

        // Three queued captures drained in order
        for (int i = 0; i < 3; i++) capture(seq_ch[i], seq_d[i]);
        check("q3_cnt", cnt_a, 5'd3);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("q3_ch%0d", i),   if_a.out_ch, seq_ch[i]);
            check($sformatf("q3_data%0d", i), if_a.out_data, seq_d[i]);
            tick();
        end
        out_ready = 1'b0;
        check("q3_valid_after", if_a.out_valid, 1'b0);
        check("q3_cnt_after",   cnt_a, 5'd0);
        check("q3_dr0",         dr_a[31:0], 32'd3);
        check("q3_dr1",         dr_a[63:32], 32'd2);

        // 17 captures into a 16-deep FIFO, both policies
        do_reset();
        for (int i = 0; i <= 16; i++) capture(2'd1, DW'(i));
        check("ovf_cnt_a", cnt_a, 5'd16);
        check("ovf_cnt_b", cnt_b, 5'd16);
        check("ovf_flag_a", ovf_a, 1'b1);
        check("ovf_flag_b", ovf_b, 1'b1);
        check("ovf_dr_a", dr_a[63:32], 32'd16);
        check("ovf_dr_b", dr_b[63:32], 32'd16);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drop_new_%0d", i), if_a.out_data, DW'(i));
            check($sformatf("drop_old_%0d", i), if_b.out_data, DW'(i + 1));
            tick();
        end
        out_ready = 1'b0;
        check("ovf_drained_a", cnt_a, 5'd0);
        check("ovf_drained_b", cnt_b, 5'd0);

        // Full FIFO with simultaneous push/pop, then clear racing an overflow
        do_reset();
        for (int i = 0; i < 16; i++) capture(2'd1, DW'(100 + i));
        check("full_ovf_a", ovf_a, 1'b0);
        out_ready = 1'b1;
        capture(2'd1, 32'd99);
        out_ready = 1'b0;
        check("pp_cnt_a", cnt_a, 5'd16);
        check("pp_cnt_b", cnt_b, 5'd16);
        check("pp_ovf_a", ovf_a, 1'b0);
        check("pp_ovf_b", ovf_b, 1'b0);
        clear_ovf = 1'b1;
        capture(2'd1, 32'd77);
        clear_ovf = 1'b0;
        check("setwins_a", ovf_a, 1'b1);
        check("setwins_b", ovf_b, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("pp_a_%0d", i), if_a.out_data,
                  (i < 15) ? DW'(101 + i) : 32'd99);
            check($sformatf("pp_b_%0d", i), if_b.out_data,
                  (i < 14) ? DW'(102 + i) : ((i == 14) ? 32'd99 : 32'd77));
            tick();
        end
        out_ready = 1'b0;
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("clear_ovf_a", ovf_a, 1'b0);

        // Out-of-range channel on the 3-channel unit, FIFO already full
        do_reset();
        for (int i = 0; i < 16; i++) capture(2'd0, DW'(i));
        capture(2'd3, 32'h55);
        check("oor_dr_c",  dr_c, {64'h0, 32'd15});
        check("oor_cnt_c", cnt_c, 5'd16);
        check("oor_ovf_c", ovf_c, 1'b0);
        check("inr_dr_a",  dr_a[127:96], 32'h55);
        check("inr_ovf_a", ovf_a, 1'b1);

        // Reset with entries queued and a capture coinciding with it
        do_reset();
        for (int i = 0; i < 5; i++) capture(2'd0, DW'(i + 1));
        check("q5_cnt", cnt_a, 5'd5);
        reset = 1'b1;
        capture(2'd2, 32'hCAFE);
        reset = 1'b0;
        check("rst2_cnt_a",   cnt_a, 5'd0);
        check("rst2_valid_a", if_a.out_valid, 1'b0);
        check("rst2_dr_a",    dr_a, '0);
        check("rst2_cnt_c",   cnt_c, 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_debug_capture_unit
`default_nettype wire
